// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/halfword/word load-store front-end for a word-only data memory
// Optional build macro MEM_ACCESS_BIGENDIAN_EN selects big-endian lane mapping.

module mem_access_unit #(
    parameter int ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqSigned,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqData,
    output logic [31:0] loadData,
    output logic        loadValid,
    output logic        addrError,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic        memRead,
    output logic        memWrite,
    input  logic [31:0] memReadData
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_RD,
        LOAD_RET,
        ST_WR,
        RMW_RD,
        RMW_MERGE,
        RMW_WR
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] data_q, data_d;

    logic [31:0] load_data_q, load_data_d;
    logic        load_valid_q, load_valid_d;
    logic        addr_error_q, addr_error_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;

    logic        req_illegal;
    logic [31:0] req_word_index;
    logic [4:0]  lane_shift;
    logic [31:0] lane_mask;
    logic [31:0] lane_raw;
    logic        lane_msb;
    logic [31:0] extracted;
    logic [31:0] merged;

    // Address bits above the memory range are intentionally dropped (accesses wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^reqAddr[31:ADDR_BITS+2];

    assign reqReady     = (state_q == IDLE);
    assign loadData     = load_data_q;
    assign loadValid    = load_valid_q;
    assign addrError    = addr_error_q;
    assign memAddress   = mem_address_q;
    assign memWriteData = mem_wdata_q;
    assign memRead      = mem_read_q;
    assign memWrite     = mem_write_q;

    always_comb begin
        req_illegal = 1'b0;
        case (reqSize)
            SIZE_BYTE: req_illegal = 1'b0;
            SIZE_HALF: req_illegal = reqAddr[0];
            SIZE_WORD: req_illegal = (reqAddr[1:0] != 2'b00);
            default:   req_illegal = 1'b1;
        endcase
    end

    assign req_word_index = {{(32-ADDR_BITS){1'b0}}, reqAddr[ADDR_BITS+1:2]};

    // Bit offset of the selected lane within the memory word.
    always_comb begin
        lane_shift = 5'd0;
        lane_mask  = 32'hFFFF_FFFF;
        case (size_q)
            SIZE_BYTE: begin
                lane_mask = 32'h0000_00FF;
`ifdef MEM_ACCESS_BIGENDIAN_EN
                lane_shift = {~lane_q, 3'b000};
`else
                lane_shift = {lane_q, 3'b000};
`endif
            end
            SIZE_HALF: begin
                lane_mask = 32'h0000_FFFF;
`ifdef MEM_ACCESS_BIGENDIAN_EN
                lane_shift = {~lane_q[1], 4'b0000};
`else
                lane_shift = {lane_q[1], 4'b0000};
`endif
            end
            default: begin
                lane_mask  = 32'hFFFF_FFFF;
                lane_shift = 5'd0;
            end
        endcase
    end

    always_comb begin
        lane_raw  = (memReadData >> lane_shift) & lane_mask;
        lane_msb  = (size_q == SIZE_BYTE) ? lane_raw[7] : lane_raw[15];
        extracted = lane_raw;
        if (size_q != SIZE_WORD && signed_q && lane_msb) begin
            extracted = lane_raw | ~lane_mask;
        end
        merged = (memReadData & ~(lane_mask << lane_shift))
               | ((data_q & lane_mask) << lane_shift);
    end

    always_comb begin
        state_d       = state_q;
        size_d        = size_q;
        signed_d      = signed_q;
        lane_d        = lane_q;
        data_d        = data_q;
        load_data_d   = load_data_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        load_valid_d  = 1'b0;
        addr_error_d  = 1'b0;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (reqValid) begin
                    if (req_illegal) begin
                        addr_error_d = 1'b1;
                    end else begin
                        size_d        = reqSize;
                        signed_d      = reqSigned;
                        lane_d        = reqAddr[1:0];
                        data_d        = reqData;
                        mem_address_d = req_word_index;
                        if (!reqWrite) begin
                            state_d    = LOAD_RD;
                            mem_read_d = 1'b1;
                        end else if (reqSize == SIZE_WORD) begin
                            state_d     = ST_WR;
                            mem_write_d = 1'b1;
                            mem_wdata_d = reqData;
                        end else begin
                            state_d    = RMW_RD;
                            mem_read_d = 1'b1;
                        end
                    end
                end
            end
            LOAD_RD:  state_d = LOAD_RET;
            LOAD_RET: begin
                load_data_d  = extracted;
                load_valid_d = 1'b1;
                state_d      = IDLE;
            end
            ST_WR:    state_d = IDLE;
            RMW_RD:   state_d = RMW_MERGE;
            RMW_MERGE: begin
                mem_wdata_d = merged;
                mem_write_d = 1'b1;
                state_d     = RMW_WR;
            end
            RMW_WR:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            size_q        <= SIZE_BYTE;
            signed_q      <= 1'b0;
            lane_q        <= 2'b00;
            data_q        <= 32'h0;
            load_data_q   <= 32'h0;
            load_valid_q  <= 1'b0;
            addr_error_q  <= 1'b0;
            mem_address_q <= 32'h0;
            mem_wdata_q   <= 32'h0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            size_q        <= size_d;
            signed_q      <= signed_d;
            lane_q        <= lane_d;
            data_q        <= data_d;
            load_data_q   <= load_data_d;
            load_valid_q  <= load_valid_d;
            addr_error_q  <= addr_error_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit against a byte-array model
// Honours MEM_ACCESS_BIGENDIAN_EN for lane ordering and directed constants.

module tb_mem_access_unit;

    localparam int AB = 8;
    localparam int NW = 1 << AB;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid, reqReady, reqWrite, reqSigned;
    logic [1:0]  reqSize;
    logic [31:0] reqAddr, reqData, loadData, memAddress, memWriteData, memReadData;
    logic        loadValid, addrError, memRead, memWrite;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_BITS(AB)) dut (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqSize(reqSize), .reqSigned(reqSigned), .reqAddr(reqAddr), .reqData(reqData),
        .loadData(loadData), .loadValid(loadValid), .addrError(addrError),
        .memAddress(memAddress), .memWriteData(memWriteData),
        .memRead(memRead), .memWrite(memWrite), .memReadData(memReadData)
    );

    // Word-only synchronous memory the unit drives.
    logic [31:0] mem [NW];
    logic [31:0] init_mem [NW];
    logic        load_init = 1'b0;
    logic [31:0] rdata = 32'h0;
    assign memReadData = rdata;

    always @(posedge clk) begin
        if (load_init) begin
            for (int i = 0; i < NW; i++) mem[i] <= init_mem[i];
        end else begin
            if (memWrite) mem[memAddress[AB-1:0]] <= memWriteData;
            if (memRead)  rdata <= mem[memAddress[AB-1:0]];
        end
    end

    // Reference: byte-addressed memory image.
    logic [7:0] ref_b [NW*4];
    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_word(input int idx);
        logic [31:0] w = 32'h0;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ACCESS_BIGENDIAN_EN
            w[24-8*k +: 8] = ref_b[idx*4+k];
`else
            w[8*k +: 8] = ref_b[idx*4+k];
`endif
        end
        return w;
    endfunction

    task automatic ref_set_word(input int idx, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ACCESS_BIGENDIAN_EN
            ref_b[idx*4+k] = w[24-8*k +: 8];
`else
            ref_b[idx*4+k] = w[8*k +: 8];
`endif
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        int n = nbytes(sz);
        int base = int'(a[AB+1:0]);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < n; i++) begin
`ifdef MEM_ACCESS_BIGENDIAN_EN
            v = (v << 8) | 32'(ref_b[base+i]);
`else
            v = v | (32'(ref_b[base+i]) << (8*i));
`endif
        end
        if (sg && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        int n = nbytes(sz);
        int base = int'(a[AB+1:0]);
        for (int i = 0; i < n; i++) begin
`ifdef MEM_ACCESS_BIGENDIAN_EN
            ref_b[base+i] = d[8*(n-1-i) +: 8];
`else
            ref_b[base+i] = d[8*i +: 8];
`endif
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".loadData"}, loadData, 32'h0);
        check({tag, ".loadValid"}, 32'(loadValid), 32'h0);
        check({tag, ".addrError"}, 32'(addrError), 32'h0);
        check({tag, ".memAddress"}, memAddress, 32'h0);
        check({tag, ".memWriteData"}, memWriteData, 32'h0);
        check({tag, ".memRead"}, 32'(memRead), 32'h0);
        check({tag, ".memWrite"}, 32'(memWrite), 32'h0);
        check({tag, ".reqReady"}, 32'(reqReady), 32'h1);
    endtask

    // One request, observed for five cycles after acceptance; expectations from the model.
    task automatic xact(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d, output logic [31:0] ld);
        int n_rd = 0, n_wr = 0, n_lv = 0, n_err = 0, n_low = 0, n_ovl = 0;
        int rd_at = 0, wr_at = 0, lv_at = 0, err_at = 0;
        logic [31:0] ra = 32'h0, wa = 32'h0, wd = 32'h0;
        logic [31:0] exp_ld, exp_wd, idx;
        logic illegal;
        logic [31:0] sig_obs, sig_exp;

        illegal = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        idx     = 32'(a[AB+1:2]);
        exp_ld  = ref_load(a, sz, sg);
        ld      = 32'h0;

        @(negedge clk);
        check({tag, ".ready_before"}, 32'(reqReady), 32'h1);
        reqValid = 1'b1; reqWrite = w; reqSize = sz; reqSigned = sg; reqAddr = a; reqData = d;
        @(posedge clk);
        #1;
        reqValid = 1'b0; reqAddr = $urandom; reqData = $urandom;
        for (int s = 1; s <= 5; s++) begin
            @(negedge clk);
            if (memRead)  begin n_rd++; rd_at = s; ra = memAddress; end
            if (memWrite) begin n_wr++; wr_at = s; wa = memAddress; wd = memWriteData; end
            if (memRead && memWrite) n_ovl++;
            if (!reqReady) n_low++;
            if (addrError) begin n_err++; err_at = s; end
            if (loadValid) begin n_lv++; lv_at = s; ld = loadData; end
        end

        sig_obs = {4'(n_rd), 4'(rd_at), 4'(n_wr), 4'(wr_at), 4'(n_lv), 4'(lv_at), 4'(n_err), 4'(err_at)};
        if (illegal) begin
            sig_exp = 32'h0000_0011;
            check({tag, ".ready_low"}, 32'(n_low), 32'd0);
        end else if (!w) begin
            sig_exp = 32'h1100_1300;
            check({tag, ".ready_low"}, 32'(n_low), 32'd2);
            check({tag, ".rd_addr"}, ra, idx);
            check({tag, ".loadData"}, ld, exp_ld);
        end else begin
            ref_store(a, sz, d);
            exp_wd = ref_word(int'(idx));
            sig_exp = (sz == 2'd2) ? 32'h0011_0000 : 32'h1113_0000;
            check({tag, ".ready_low"}, 32'(n_low), (sz == 2'd2) ? 32'd1 : 32'd3);
            check({tag, ".wr_addr"}, wa, idx);
            check({tag, ".wr_data"}, wd, exp_wd);
            if (sz != 2'd2) check({tag, ".rd_addr"}, ra, idx);
        end
        check({tag, ".timing"}, sig_obs, sig_exp);
        check({tag, ".overlap"}, 32'(n_ovl), 32'd0);
    endtask

`ifdef MEM_ACCESS_BIGENDIAN_EN
    localparam logic [31:0] EXP_SB7 = 32'hFFFF_FFBB;
    localparam logic [31:0] EXP_UB7 = 32'h0000_00BB;
    localparam logic [31:0] EXP_SH4 = 32'hFFFF_8899;
    localparam logic [31:0] EXP_W_CC5 = 32'h88CC_AABB;
`else
    localparam logic [31:0] EXP_SB7 = 32'hFFFF_FF88;
    localparam logic [31:0] EXP_UB7 = 32'h0000_0088;
    localparam logic [31:0] EXP_SH4 = 32'hFFFF_AABB;
    localparam logic [31:0] EXP_W_CC5 = 32'h8899_CCBB;
`endif

    initial begin
        logic [31:0] ld;
        logic [31:0] a;
        logic        wr_seen;

        rst = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'd0; reqSigned = 1'b0;
        reqAddr = 32'h0; reqData = 32'h0;
        for (int i = 0; i < NW; i++) begin
            init_mem[i] = $urandom;
            ref_set_word(i, init_mem[i]);
        end
        load_init = 1'b1;
        repeat (2) @(posedge clk);
        load_init = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        xact("st_w4", 1'b1, 2'd2, 1'b0, 32'h4, 32'h8899_AABB, ld);
        xact("ld_w4", 1'b0, 2'd2, 1'b1, 32'h4, 32'h0, ld);
        check("ld_w4.const", ld, 32'h8899_AABB);
        xact("ld_sb7", 1'b0, 2'd0, 1'b1, 32'h7, 32'h0, ld);
        check("ld_sb7.const", ld, EXP_SB7);
        xact("ld_ub7", 1'b0, 2'd0, 1'b0, 32'h7, 32'h0, ld);
        check("ld_ub7.const", ld, EXP_UB7);
        xact("ld_sh4", 1'b0, 2'd1, 1'b1, 32'h4, 32'h0, ld);
        check("ld_sh4.const", ld, EXP_SH4);
`ifdef MEM_ACCESS_BIGENDIAN_EN
        xact("ld_sb4_be", 1'b0, 2'd0, 1'b1, 32'h4, 32'h0, ld);
        check("ld_sb4_be.const", ld, 32'hFFFF_FF88);
        xact("st_b4_be", 1'b1, 2'd0, 1'b0, 32'h4, 32'h0000_00CC, ld);
        @(negedge clk);
        check("st_b4_be.mem", mem[1], 32'hCC99_AABB);
        xact("restore_be", 1'b1, 2'd2, 1'b0, 32'h4, 32'h8899_AABB, ld);
`endif
        xact("st_b5", 1'b1, 2'd0, 1'b0, 32'h5, 32'h0000_00CC, ld);
        @(negedge clk);
        check("st_b5.mem", mem[1], EXP_W_CC5);
        xact("restore", 1'b1, 2'd2, 1'b0, 32'h4, 32'h8899_AABB, ld);

        xact("err_h5", 1'b0, 2'd1, 1'b1, 32'h5, 32'h0, ld);
        xact("err_w6", 1'b1, 2'd2, 1'b0, 32'h6, 32'hDEAD_BEEF, ld);
        xact("err_sz3", 1'b0, 2'd3, 1'b0, 32'h8, 32'h0, ld);
        @(negedge clk);
        check("err.mem1", mem[1], 32'h8899_AABB);

        // Reset while the RMW is between its read and its write.
        @(negedge clk);
        reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'd0; reqSigned = 1'b0;
        reqAddr = 32'h4; reqData = 32'h11;
        @(posedge clk);
        #1 reqValid = 1'b0;
        @(negedge clk);
        check("rmw_rst.read", 32'(memRead), 32'h1);
        wr_seen = memWrite;
        @(negedge clk);
        wr_seen = wr_seen | memWrite;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rmw_rst");
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            wr_seen = wr_seen | memWrite;
        end
        check("rmw_rst.no_write", 32'(wr_seen), 32'h0);
        check("rmw_rst.mem1", mem[1], 32'h8899_AABB);

        for (int t = 0; t < 200; t++) begin
            logic [1:0] sz;
            sz = 2'($urandom_range(0, 3));
            a  = $urandom & ~32'h0000_03C0;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            xact($sformatf("rnd%0d", t), 1'($urandom), sz, 1'($urandom), a, $urandom, ld);
        end

        @(negedge clk);
        for (int i = 0; i < NW; i++) begin
            check($sformatf("final.mem%0d", i), mem[i], ref_word(i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
